// File: rtl/call_control_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : call_control_responder                                        |
// | Brief   : Call-control FSM between the UI command port and the network  |
// |           control-message transport.                                    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module call_control_responder #(
    parameter logic [7:0]  MY_NUM       = 8'd0,
    parameter logic [31:0] RING_TIMEOUT = 32'd270000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] command,
    input  logic [7:0] phn_num,
    output logic [2:0] inc_command,
    output logic [7:0] caller_id,
    output logic       net_tx_valid,
    input  logic       net_tx_ready,
    output logic [2:0] net_tx_type,
    output logic [7:0] net_tx_dst,
    input  logic       net_rx_valid,
    input  logic [2:0] net_rx_type,
    input  logic [7:0] net_rx_src,
    input  logic [7:0] net_rx_dst,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ_TX    = 3'd1;
    localparam logic [2:0] S_WAIT_ANS  = 3'd2;
    localparam logic [2:0] S_RINGING   = 3'd3;
    localparam logic [2:0] S_ACK_TX    = 3'd4;
    localparam logic [2:0] S_REJ_TX    = 3'd5;
    localparam logic [2:0] S_CONNECTED = 3'd6;
    localparam logic [2:0] S_END_TX    = 3'd7;

    localparam logic [2:0] c_cmd_dial   = 3'd1;
    localparam logic [2:0] c_cmd_accept = 3'd2;
    localparam logic [2:0] c_cmd_reject = 3'd3;
    localparam logic [2:0] c_cmd_end    = 3'd4;

    localparam logic [2:0] c_msg_req = 3'd1;
    localparam logic [2:0] c_msg_ack = 3'd2;
    localparam logic [2:0] c_msg_rej = 3'd3;
    localparam logic [2:0] c_msg_end = 3'd4;

    localparam logic [2:0] c_inc_conn  = 3'd1;
    localparam logic [2:0] c_inc_rej   = 3'd2;
    localparam logic [2:0] c_inc_noans = 3'd3;
    localparam logic [2:0] c_inc_ring  = 3'd5;
    localparam logic [2:0] c_inc_ended = 3'd6;

    localparam logic [31:0] c_timer_max = RING_TIMEOUT - 32'd1;

    logic [2:0]  r_state;
    logic [31:0] r_timer;
    logic [2:0]  r_cmd_prev;
    logic [2:0]  r_inc;
    logic [7:0]  r_caller;
    logic        r_tx_valid;
    logic        r_tx_fsm;
    logic [2:0]  r_tx_type;
    logic [7:0]  r_tx_dst;
    logic        r_rej_pend;
    logic [7:0]  r_rej_dst;

    logic        w_cmd_edge;
    logic        w_rx_ok;
    logic        w_rx_caller;
    logic        w_busy_req;
    logic        w_fsm_hs;
    logic        w_timeout;
    logic [2:0]  w_state_next;
    logic [2:0]  w_inc_next;
    logic [7:0]  w_caller_next;
    logic [2:0]  w_fsm_type;
    logic        w_load_fsm;
    logic        w_load_rej;

    assign w_cmd_edge  = (command != r_cmd_prev) && (command != 3'd0);
    assign w_rx_ok     = net_rx_valid && (net_rx_dst == MY_NUM);
    assign w_rx_caller = w_rx_ok && (net_rx_src == r_caller);
    assign w_busy_req  = w_rx_ok && (net_rx_type == c_msg_req) && (r_state != S_IDLE);
    assign w_fsm_hs    = r_tx_valid && r_tx_fsm && net_tx_ready;
    assign w_timeout   = (r_timer == c_timer_max);

    // Received messages act first; a UI edge is then judged against the state rx led to.
    always_comb begin
        w_state_next  = r_state;
        w_inc_next    = r_inc;
        w_caller_next = r_caller;
        case (r_state)
            S_IDLE: begin
                if (w_rx_ok && (net_rx_type == c_msg_req)) begin
                    w_caller_next = net_rx_src;
                    w_inc_next    = c_inc_ring;
                    w_state_next  = S_RINGING;
                end
            end
            S_REQ_TX:  if (w_fsm_hs) w_state_next = S_WAIT_ANS;
            S_WAIT_ANS: begin
                if (w_rx_caller && (net_rx_type == c_msg_ack)) begin
                    w_inc_next   = c_inc_conn;
                    w_state_next = S_CONNECTED;
                end else if (w_rx_caller && (net_rx_type == c_msg_rej)) begin
                    w_inc_next   = c_inc_rej;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_inc_next   = c_inc_noans;
                    w_state_next = S_END_TX;
                end
            end
            S_RINGING: begin
                if (w_rx_caller && (net_rx_type == c_msg_end)) begin
                    w_inc_next   = c_inc_ended;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_inc_next   = c_inc_noans;
                    w_state_next = S_IDLE;
                end
            end
            S_ACK_TX: begin
                if (w_fsm_hs) begin
                    w_inc_next   = c_inc_conn;
                    w_state_next = S_CONNECTED;
                end
            end
            S_REJ_TX: begin
                if (w_fsm_hs) begin
                    w_inc_next   = c_inc_ended;
                    w_state_next = S_IDLE;
                end
            end
            S_CONNECTED: begin
                if (w_rx_caller && (net_rx_type == c_msg_end)) begin
                    w_inc_next   = c_inc_ended;
                    w_state_next = S_IDLE;
                end
            end
            S_END_TX: begin
                if (w_fsm_hs) begin
                    if (r_inc != c_inc_noans) w_inc_next = c_inc_ended;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_cmd_edge) begin
            case (w_state_next)
                S_IDLE: begin
                    if (command == c_cmd_dial) begin
                        w_caller_next = phn_num;
                        w_state_next  = S_REQ_TX;
                    end
                end
                S_WAIT_ANS, S_CONNECTED: begin
                    if (command == c_cmd_end) w_state_next = S_END_TX;
                end
                S_RINGING: begin
                    if (command == c_cmd_accept)      w_state_next = S_ACK_TX;
                    else if (command == c_cmd_reject) w_state_next = S_REJ_TX;
                end
                default: ;
            endcase
        end
    end

    // Each *_TX state owns one message; it is loaded as soon as the transmitter is idle.
    always_comb begin
        w_fsm_type = 3'd0;
        case (w_state_next)
            S_REQ_TX: w_fsm_type = c_msg_req;
            S_ACK_TX: w_fsm_type = c_msg_ack;
            S_REJ_TX: w_fsm_type = c_msg_rej;
            S_END_TX: w_fsm_type = c_msg_end;
            default:  w_fsm_type = 3'd0;
        endcase
    end

    assign w_load_fsm = !r_tx_valid && (w_fsm_type != 3'd0);
    assign w_load_rej = !r_tx_valid && r_rej_pend && !w_load_fsm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= 32'd0;
            r_cmd_prev <= 3'd0;
            r_inc      <= 3'd0;
            r_caller   <= 8'd0;
            r_tx_valid <= 1'b0;
            r_tx_fsm   <= 1'b0;
            r_tx_type  <= 3'd0;
            r_tx_dst   <= 8'd0;
            r_rej_pend <= 1'b0;
            r_rej_dst  <= 8'd0;
        end else begin
            r_cmd_prev <= command;
            r_state    <= w_state_next;
            r_inc      <= w_inc_next;
            r_caller   <= w_caller_next;

            if (w_state_next != r_state) begin
                r_timer <= 32'd0;
            end else if (((r_state == S_WAIT_ANS) || (r_state == S_RINGING)) && !w_timeout) begin
                r_timer <= r_timer + 32'd1;
            end

            if (r_tx_valid && net_tx_ready) r_tx_valid <= 1'b0;

            if (w_load_fsm) begin
                r_tx_valid <= 1'b1;
                r_tx_fsm   <= 1'b1;
                r_tx_type  <= w_fsm_type;
                r_tx_dst   <= w_caller_next;
            end else if (w_load_rej) begin
                r_tx_valid <= 1'b1;
                r_tx_fsm   <= 1'b0;
                r_tx_type  <= c_msg_rej;
                r_tx_dst   <= r_rej_dst;
            end

            if (w_load_rej) r_rej_pend <= 1'b0;
            if (w_busy_req && (!r_rej_pend || w_load_rej)) begin
                r_rej_pend <= 1'b1;
                r_rej_dst  <= net_rx_src;
            end
        end
    end

    assign inc_command  = r_inc;
    assign caller_id    = r_caller;
    assign net_tx_valid = r_tx_valid;
    assign net_tx_type  = r_tx_type;
    assign net_tx_dst   = r_tx_dst;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_call_control_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : tb_call_control_responder                                     |
// | Brief   : Directed bench with a transmit-message scoreboard.            |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_call_control_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] command;
    logic [7:0] phn_num;
    logic [2:0] inc_command;
    logic [7:0] caller_id;
    logic       net_tx_valid;
    logic       net_tx_ready;
    logic [2:0] net_tx_type;
    logic [7:0] net_tx_dst;
    logic       net_rx_valid;
    logic [2:0] net_rx_type;
    logic [7:0] net_rx_src;
    logic [7:0] net_rx_dst;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [10:0] q_exp[$];
    logic [10:0] q_obs[$];

    call_control_responder #(
        .MY_NUM      (8'h04),
        .RING_TIMEOUT(32'd16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .command     (command),
        .phn_num     (phn_num),
        .inc_command (inc_command),
        .caller_id   (caller_id),
        .net_tx_valid(net_tx_valid),
        .net_tx_ready(net_tx_ready),
        .net_tx_type (net_tx_type),
        .net_tx_dst  (net_tx_dst),
        .net_rx_valid(net_rx_valid),
        .net_rx_type (net_rx_type),
        .net_rx_src  (net_rx_src),
        .net_rx_dst  (net_rx_dst),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        if (!reset && net_tx_valid && net_tx_ready)
            q_obs.push_back({net_tx_type, net_tx_dst});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void expect_tx(input logic [2:0] t, input logic [7:0] d);
        q_exp.push_back({t, d});
    endfunction

    task automatic sb_check(input string tag);
        int n = 0;
        logic [10:0] obs;
        logic [10:0] exp;
        while (q_obs.size() == 0 && n < 50) begin
            tick(1);
            n++;
        end
        total++;
        if (q_obs.size() == 0 || q_exp.size() == 0) begin
            bad++;
            $error("FAIL %s: observed msgs=%0d expected msgs=%0d", tag, q_obs.size(), q_exp.size());
        end else begin
            obs = q_obs.pop_front();
            exp = q_exp.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed type/dst=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic rx_pulse(input logic [2:0] t, input logic [7:0] src, input logic [7:0] dst);
        net_rx_valid = 1'b1;
        net_rx_type  = t;
        net_rx_src   = src;
        net_rx_dst   = dst;
        tick(1);
        net_rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        command      = 3'd0;
        phn_num      = 8'd0;
        net_tx_ready = 1'b0;
        net_rx_valid = 1'b0;
        net_rx_type  = 3'd0;
        net_rx_src   = 8'd0;
        net_rx_dst   = 8'd0;
        tick(3);
        chk("rst_outputs", {inc_command, caller_id, net_tx_valid, net_tx_type, net_tx_dst, busy}, 0);
        reset = 1'b0;
        tick(1);

        // Accept in IDLE and a message for another number are both ignored
        command = 3'd2;
        tick(2);
        chk("accept_in_idle", {busy, net_tx_valid}, 0);
        command = 3'd0;
        rx_pulse(3'd1, 8'h07, 8'h05);
        chk("rx_wrong_dst", {inc_command, busy}, 0);

        // Incoming call, accept, remote hang-up
        rx_pulse(3'd1, 8'h07, 8'h04);
        chk("ring_inc", inc_command, 5);
        chk("ring_caller", caller_id, 8'h07);
        command      = 3'd2;
        net_tx_ready = 1'b1;
        expect_tx(3'd2, 8'h07);
        tick(2);
        chk("accept_inc", inc_command, 1);
        sb_check("accept_ack");
        command      = 3'd0;
        net_tx_ready = 1'b0;
        rx_pulse(3'd4, 8'h07, 8'h04);
        chk("remote_end", {inc_command, busy}, {3'd6, 1'b0});

        // Outgoing call with backpressure
        command = 3'd1;
        phn_num = 8'h04;
        expect_tx(3'd1, 8'h04);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("req_held", {net_tx_valid, net_tx_type, net_tx_dst}, {1'b1, 3'd1, 8'h04});
            tick(1);
        end
        net_tx_ready = 1'b1;
        tick(1);
        chk("req_valid_drop", net_tx_valid, 0);
        net_tx_ready = 1'b0;
        command      = 3'd0;
        rx_pulse(3'd2, 8'h04, 8'h04);
        chk("out_connected", inc_command, 1);
        sb_check("req_backpressure");

        // Second caller while connected gets a reject, call state untouched
        net_tx_ready = 1'b1;
        expect_tx(3'd3, 8'h09);
        rx_pulse(3'd1, 8'h09, 8'h04);
        tick(2);
        chk("busy_rej_state", {inc_command, busy}, {3'd1, 1'b1});
        sb_check("busy_rej_msg");

        // Local hang-up
        command = 3'd4;
        expect_tx(3'd4, 8'h04);
        tick(2);
        chk("local_end", {inc_command, busy}, {3'd6, 1'b0});
        sb_check("local_end_msg");
        command      = 3'd0;
        net_tx_ready = 1'b0;
        tick(1);

        // Outgoing rejected; dial held for 20 cycles sends only one request
        command      = 3'd1;
        net_tx_ready = 1'b1;
        expect_tx(3'd1, 8'h04);
        tick(2);
        rx_pulse(3'd3, 8'h04, 8'h04);
        chk("remote_rej", {inc_command, busy}, {3'd2, 1'b0});
        tick(17);
        chk("single_req", q_obs.size(), 1);
        sb_check("rej_req_msg");
        command      = 3'd0;
        net_tx_ready = 1'b0;
        tick(1);

        // No answer: timeout 16 cycles after the request handshake
        command      = 3'd1;
        net_tx_ready = 1'b1;
        expect_tx(3'd1, 8'h04);
        tick(1);
        tick(1);
        net_tx_ready = 1'b0;
        command      = 3'd0;
        sb_check("noans_req");
        tick(15);
        chk("pre_timeout", {inc_command, net_tx_valid}, {3'd2, 1'b0});
        tick(1);
        chk("timeout_inc", inc_command, 3);
        chk("timeout_end_tx", {net_tx_valid, net_tx_type, net_tx_dst}, {1'b1, 3'd4, 8'h04});
        expect_tx(3'd4, 8'h04);
        net_tx_ready = 1'b1;
        tick(1);
        chk("timeout_keep3", {inc_command, busy}, {3'd3, 1'b0});
        sb_check("timeout_end_msg");
        net_tx_ready = 1'b0;

        // Reset in the middle of a call
        rx_pulse(3'd1, 8'h07, 8'h04);
        command      = 3'd2;
        net_tx_ready = 1'b1;
        expect_tx(3'd2, 8'h07);
        tick(2);
        chk("pre_reset_conn", inc_command, 1);
        sb_check("pre_reset_ack");
        net_tx_ready = 1'b0;
        reset        = 1'b1;
        tick(1);
        chk("mid_reset", {inc_command, caller_id, net_tx_valid, net_tx_type, net_tx_dst, busy}, 0);
        reset   = 1'b0;
        command = 3'd0;
        tick(1);
        rx_pulse(3'd1, 8'h09, 8'h04);
        chk("post_reset_ring", {inc_command, caller_id, busy}, {3'd5, 8'h09, 1'b1});
        tick(2);
        chk("no_stray_tx", {q_obs.size(), q_exp.size()}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/call_control_responder.md
Name: call_control_responder

Overview:
Application-layer end of the UI command interface. It accepts level-encoded `command`/`phn_num` from `user_interface` and reports call progress back on `inc_command`. It translates UI actions into network control messages over a valid/ready transmit port and decodes received control messages. The block sits between `user_interface` and the packet/transport layer.

Parameters:
- MY_NUM, 8'd0: local phone number; received messages are accepted only if `net_rx_dst` equals MY_NUM.
- RING_TIMEOUT, 32'd270000000: cycles to wait for an answer or ringing before giving up (10 s at 27 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- command  input  3  UI request, level: 0 none, 1 dial, 2 accept, 3 reject, 4 end call
- phn_num  input  8  number to dial; sampled when dial is accepted
- inc_command  output  3  status to UI, held until the next event: 0 none, 1 connected, 2 rejected, 3 no answer, 5 incoming call, 6 call ended
- caller_id  output  8  remote number of the current or last call
- net_tx_valid  output  1  transmit message valid
- net_tx_ready  input  1  transport accepts the message
- net_tx_type  output  3  1 CALL_REQ, 2 CALL_ACK, 3 CALL_REJ, 4 CALL_END
- net_tx_dst  output  8  destination number
- net_rx_valid  input  1  one-cycle received-message strobe
- net_rx_type  input  3  same encoding as `net_tx_type`
- net_rx_src  input  8  sender number
- net_rx_dst  input  8  addressed number
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; `inc_command`=0, `caller_id`=0, `net_tx_valid`=0, `net_tx_type`=0, `net_tx_dst`=0, `busy`=0; timer=0; `cmd_prev`=0. Reset mid-call aborts silently and sends no CALL_END.
- Command edge detect: a UI command acts only on the cycle where `command` != `cmd_prev` and `command` != 0. `cmd_prev` updates every cycle. Holding a level never re-triggers.
- Transmit: loading a message sets `net_tx_valid`=1 with type/dst. Type/dst stay stable until the cycle where `net_tx_ready`=1, and valid drops the following cycle. Only one message is outstanding. A new send is never issued while valid is high; the FSM waits in a *_TX state.
- Received messages count only when `net_rx_valid`=1 and `net_rx_dst`==MY_NUM. All others are ignored.
- States and transitions:
  - IDLE
    - dial edge: `caller_id`<=`phn_num`; send CALL_REQ to `phn_num`; go to REQ_TX.
    - rx CALL_REQ: `caller_id`<=`net_rx_src`; `inc_command`<=5; go to RINGING.
  - REQ_TX: on tx handshake, timer<=0 and go to WAIT_ANS.
  - WAIT_ANS (timer increments)
    - rx CALL_ACK from `caller_id`: `inc_command`<=1; go to CONNECTED.
    - rx CALL_REJ from `caller_id`: `inc_command`<=2; go to IDLE.
    - timer==RING_TIMEOUT-1: `inc_command`<=3; send CALL_END; go to END_TX.
    - end edge: send CALL_END; go to END_TX.
  - RINGING (timer increments)
    - accept edge: send CALL_ACK; go to ACK_TX.
    - reject edge: send CALL_REJ; go to REJ_TX.
    - rx CALL_END from `caller_id`: `inc_command`<=6; go to IDLE.
    - timeout: `inc_command`<=3; go to IDLE.
  - ACK_TX: on handshake, `inc_command`<=1; go to CONNECTED.
  - REJ_TX: on handshake, `inc_command`<=6; go to IDLE.
  - CONNECTED
    - end edge: send CALL_END; go to END_TX.
    - rx CALL_END from `caller_id`: `inc_command`<=6; go to IDLE.
  - END_TX: on handshake, `inc_command`<=6 (unless it is already 3); go to IDLE.
- Receive priority and side conditions:
  - A second CALL_REQ while not IDLE: reply CALL_REJ to its src through a one-deep pending-reject register. The reply is sent once the transmitter is free and does not change state or `inc_command`.
  - A UI edge and a valid rx in the same cycle: rx is processed first. The UI edge is honoured only if it is still legal in the new state; otherwise it is dropped.
  - Commands illegal in the current state (e.g. accept in IDLE) are ignored.
- Timer: 32-bit, cleared on every state entry, saturates at RING_TIMEOUT-1.

Test Plan:
- Incoming, accept, remote hang-up (MY_NUM=8'h04):
  - rx CALL_REQ src=8'h07 dst=8'h04 -> `inc_command`=5, `caller_id`=8'h07.
  - command=2 with ready=1 -> tx CALL_ACK dst=8'h07, `inc_command`=1.
  - rx CALL_END -> `inc_command`=6, `busy`=0.
- Outgoing with backpressure: command=1, phn_num=8'h04, `net_tx_ready` low for 5 cycles -> `net_tx_valid` held with type=1 dst=8'h04 throughout; rx CALL_ACK -> `inc_command`=1.
- Outgoing, rejected: rx CALL_REJ from 8'h04 -> `inc_command`=2, state IDLE. Dial held at command=1 for 20 cycles produces exactly one CALL_REQ.
- No answer (RING_TIMEOUT=16): dial, then no rx -> 16 cycles after the handshake, `inc_command`=3 and CALL_END is sent.
- Busy reject: while CONNECTED, rx CALL_REQ src=8'h09 -> CALL_REJ sent to 8'h09; `inc_command` stays 1.
- Reset mid-call: while CONNECTED, pulse reset -> all outputs 0, `net_tx_valid`=0, a later rx CALL_REQ rings normally.
